m_ext_unit: RTL and testbench
=============================

// Module: m_ext_unit
// PURPOSE
//  Iterative RV32M multiply/divide responder serving the execute stage. EX offers a decoded
//  OP-class instruction with its forwarded operands. The unit accepts only the M-extension
//  encodings, computes the result over several cycles, and returns it with busy/ready/wr/dest.
//  The hazard unit stalls the pipeline on (busy || ready); EX/MEM captures result/dest/wr on ready.
// PARAMETERS
//  XLEN       32          operand/result width; only 32 is supported
//  OPCODE_OP  7'b0110011  opcode accepted
//  FUNCT7_M   7'b0000001  funct7 selecting the M extension
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  invalid_inst in   1   EX flags instruction as not handled by the base ALU (M candidate)
//  instruction  in   32  EX instruction word: opcode[6:0], rd[11:7], funct3[14:12], funct7[31:25]
//  op1          in   32  forwarded rs1 value
//  op2          in   32  forwarded rs2 value
//  flush        in   1   pipeline flush: abort in-flight op, block accept
//  busy         out  1   computation in progress
//  ready        out  1   one-cycle result-valid pulse
//  wr           out  1   ready && dest!=0; register-file write enable toward EX/MEM
//  dest         out  5   rd of the op being completed
//  result       out  32  result, valid while ready=1
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy, ready, wr, dest, result all 0. Also applies mid-operation,
//    with no completion.
//  - accept = IDLE && invalid_inst && opcode==OPCODE_OP && funct7==FUNCT7_M && !flush.
//    On the accept edge, latch funct3, rd, op1, op2.
//  - FSM IDLE -> CALC -> DONE -> IDLE. DONE lasts exactly 1 cycle: ready=1, busy=0.
//  - busy=1 in every CALC cycle. A second accept is possible in the cycle after DONE.
//  - CALC runs 32 iterations, one per cycle, so busy is high 32 cycles.
//    Accept edge to ready rising = 33 cycles.
//    MUL*: radix-2 shift-add on a 64-bit product register.
//    DIV*: restoring division, 1 quotient bit per cycle.
//  - Signed ops (MULH, MULHSU, DIV, REM): operate on magnitudes, then fix the sign when
//    registering into DONE.
//    MULHSU: op1 signed, op2 unsigned. Product sign = sign(op1)^sign(op2).
//    Quotient sign = sign(op1)^sign(op2). Remainder takes the dividend's sign.
//  - funct3 result selection:
//    0 MUL -> prod[31:0]; 1/2/3 MULH/MULHSU/MULHU -> prod[63:32];
//    4/5 DIV/DIVU -> quotient; 6/7 REM/REMU -> remainder.
//  - Fast path: IDLE -> DONE directly, so ready rises 1 cycle after the accept edge.
//    Divide by zero: quotient=32'hFFFFFFFF; remainder=op1.
//    Signed overflow 0x80000000 / -1: DIV=0x80000000; REM=0.
//  - flush while CALC: return to IDLE next edge, no ready, result/dest unchanged.
//    flush during DONE has no effect; ready still pulses.
//  - result/dest hold their value after DONE until the next DONE.
//  - ready=0 and wr=0 outside DONE.
//  - Simultaneous flush and valid M candidate in IDLE: no accept.
//  - Non-M instruction with invalid_inst=1: ignored, stays IDLE.
// CONFIGURATION
//  M_UNIT_EARLY_OUT_EN defined: MUL* leaves CALC as soon as the remaining multiplier bits are 0.
//    Minimum 1 CALC cycle, so the latency for multiplier m = 1 + max(1, bit index of msb(m)+1).
//    DIV* is unchanged.
//  M_UNIT_EARLY_OUT_EN undefined: every MUL*/DIV* takes exactly 32 CALC cycles.
// TESTING
//  1. MUL rd=5, op1=7, op2=32'hFFFFFFFD -> ready 33 cycles after accept;
//     result=32'hFFFFFFEB, dest=5, wr=1. With EN, op2=3 completes in 3 cycles.
//  2. MULHU op1=op2=32'hFFFFFFFF -> 32'hFFFFFFFE.
//     MULH op1=32'h80000000, op2=2 -> 32'hFFFFFFFF.
//  3. DIV op1=-7, op2=2 -> 32'hFFFFFFFD. REM same operands -> 32'hFFFFFFFF.
//     DIVU 100/7 -> 14. REMU 100/7 -> 2.
//  4. DIVU op1=5, op2=0 -> 32'hFFFFFFFF. REMU op1=5, op2=0 -> 5.
//     DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000, REM -> 0. All ready 1 cycle after accept.
//  5. MUL with rd=0 -> ready=1, wr=0. ADD (funct7=0) with invalid_inst=1 -> no busy.
//  6. flush at CALC cycle 10 -> no ready, IDLE next cycle; a back-to-back accept then completes.
//     rst asserted at CALC cycle 5 -> all outputs 0 immediately.

Source files
------------

// File: rtl/m_ext_unit.sv
// m_ext_unit: iterative RV32M multiply/divide unit beside the execute stage.
// Accepts OP-class instructions with funct7=0000001, runs a 32-step radix-2
// shift-add multiply or restoring divide on operand magnitudes, applies the
// sign on the way into DONE and pulses ready for one cycle.
// Divide-by-zero and signed overflow bypass the iteration (IDLE -> DONE).
// Optional build macro: M_UNIT_EARLY_OUT_EN -- multiplies leave CALC as soon
// as no multiplier bits remain (at least one CALC cycle); divides unchanged.
module m_ext_unit #(
  parameter int         XLEN      = 32,
  parameter logic [6:0] OPCODE_OP = 7'b0110011,
  parameter logic [6:0] FUNCT7_M  = 7'b0000001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            invalid_inst,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            busy,
  output logic            ready,
  output logic            wr,
  output logic [4:0]      dest,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  // Magnitude of a value that is interpreted as signed only when is_signed is set.
  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                input logic is_signed);
    if (is_signed && (v < 0)) return $unsigned(-v);
    return $unsigned(v);
  endfunction

  // Conditional two's-complement negation of a 64-bit product.
  function automatic logic [2*XLEN-1:0] apply_sign_w(input logic [2*XLEN-1:0] v,
                                                     input logic neg);
    if (neg) return $unsigned(-$signed(v));
    return v;
  endfunction

  // Conditional two's-complement negation of a quotient/remainder.
  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v,
                                                 input logic neg);
    if (neg) return $unsigned(-$signed(v));
    return v;
  endfunction

  // Decoded fields of the offered instruction.
  logic [6:0]  opcode_in, funct7_in;
  logic [2:0]  funct3_in;
  logic [4:0]  rd_in;
  logic        unused_bits;
  assign opcode_in   = instruction[6:0];
  assign rd_in       = instruction[11:7];
  assign funct3_in   = instruction[14:12];
  assign funct7_in   = instruction[31:25];
  assign unused_bits = ^instruction[24:15];

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        dest_q, dest_d;

  // Datapath registers (no reset: always loaded on accept before use).
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic              negq_q, negr_q;
  logic [2*XLEN-1:0] mcand_q, prod_q;
  logic [XLEN-1:0]   mplier_q, divisor_q, rem_q, dvd_q;

  // Accept-side operand conditioning.
  logic              accept, sgn1, sgn2, neg1, neg2, div_zero, div_ovf, fast;
  logic [XLEN-1:0]   mag1, mag2, fast_res;
  logic signed [XLEN-1:0] op1_s, op2_s;

  assign op1_s  = op1;
  assign op2_s  = op2;
  assign accept = (state_q == S_IDLE) && invalid_inst && (opcode_in == OPCODE_OP) &&
                  (funct7_in == FUNCT7_M) && !flush;
  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
  assign sgn1   = (funct3_in == 3'd1) || (funct3_in == 3'd2) ||
                  (funct3_in == 3'd4) || (funct3_in == 3'd6);
  assign sgn2   = (funct3_in == 3'd1) || (funct3_in == 3'd4) || (funct3_in == 3'd6);
  assign neg1   = sgn1 && (op1_s < 0);
  assign neg2   = sgn2 && (op2_s < 0);
  assign mag1   = magnitude(op1_s, sgn1);
  assign mag2   = magnitude(op2_s, sgn2);

  assign div_zero = funct3_in[2] && (op2 == '0);
  assign div_ovf  = funct3_in[2] && !funct3_in[0] &&
                    (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
  assign fast     = div_zero || div_ovf;
  // Zero divisor: quotient all-ones, remainder is the dividend.
  // Overflow: quotient is the most negative value, remainder 0.
  assign fast_res = div_zero ? (funct3_in[1] ? op1 : '1)
                             : (funct3_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

  // One iteration of each algorithm.
  logic [2*XLEN-1:0] prod_nxt, prod_fix;
  logic [XLEN:0]     trial, diff;
  logic              qbit, last_iter;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, final_res;

  assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign trial    = {rem_q, dvd_q[XLEN-1]};
  assign diff     = trial - {1'b0, divisor_q};
  assign qbit     = !diff[XLEN];
  assign rem_nxt  = qbit ? diff[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_nxt  = {dvd_q[XLEN-2:0], qbit};

`ifdef M_UNIT_EARLY_OUT_EN
  assign last_iter = (cnt_q == 5'd31) || (!f3_q[2] && (mplier_q[XLEN-1:1] == '0));
`else
  assign last_iter = (cnt_q == 5'd31);
`endif

  assign prod_fix = apply_sign_w(prod_nxt, negq_q);

  // Select and sign-correct the completed result.
  always_comb begin
    final_res = prod_fix[XLEN-1:0];
    case (f3_q)
      3'd0:       final_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       final_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5: final_res = apply_sign(quo_nxt, negq_q);
      default:    final_res = apply_sign(rem_nxt, negr_q);
    endcase
  end

  // FSM next state, iteration counter and result/dest capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dest_d   = dest_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (fast) begin
            state_d  = S_DONE;
            result_d = fast_res;
            dest_d   = rd_in;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          state_d  = S_DONE;
          result_d = final_res;
          dest_d   = rd_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and architecturally visible registers, async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dest_q   <= dest_d;
    end
  end

  // Operand latch on accept, then one multiply or divide step per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q      <= funct3_in;
      rd_q      <= rd_in;
      negq_q    <= neg1 ^ neg2;
      negr_q    <= neg1;
      mcand_q   <= {{XLEN{1'b0}}, mag1};
      mplier_q  <= mag2;
      prod_q    <= '0;
      divisor_q <= mag2;
      rem_q     <= '0;
      dvd_q     <= mag1;
    end else if (state_q == S_CALC) begin
      if (!f3_q[2]) begin
        prod_q   <= prod_nxt;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end else begin
        rem_q <= rem_nxt;
        dvd_q <= quo_nxt;
      end
    end
  end

  assign busy   = (state_q == S_CALC);
  assign ready  = (state_q == S_DONE);
  assign wr     = ready && (dest_q != 5'd0);
  assign dest   = dest_q;
  assign result = result_q;

endmodule

// File: tb/tb_m_ext_unit.sv
// Directed bench for m_ext_unit: hand-computed results, latencies and
// control behaviour (reset, ignore, flush, back-to-back).
module tb_m_ext_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        invalid_inst = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        flush = 1'b0;
  logic        busy, ready, wr;
  logic [4:0]  dest;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  int          lat;
  logic [31:0] res;
  logic [4:0]  dst;
  logic        w;

  m_ext_unit dut (
    .clk(clk), .rst(rst), .invalid_inst(invalid_inst), .instruction(instruction),
    .op1(op1), .op2(op2), .flush(flush), .busy(busy), .ready(ready), .wr(wr),
    .dest(dest), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected accept-to-ready latency of a multiply with multiplier magnitude m.
  function automatic int mul_lat(input logic [31:0] m);
`ifdef M_UNIT_EARLY_OUT_EN
    int k;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return 1 + k;
`else
    return 33;
`endif
  endfunction

  // Present an instruction for one accept edge, then withdraw it.
  task automatic start_op(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    invalid_inst = 1'b1;
    instruction  = {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    op1 = a;
    op2 = b;
    @(posedge clk);
    #1;
    invalid_inst = 1'b0;
    instruction  = '0;
    op1 = 32'hDEADBEEF;
    op2 = 32'h12345678;
  endtask

  // Issue an M op, wait (bounded) for ready, capture outputs, step past DONE.
  task automatic run_op(input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b,
                        output int l, output logic [31:0] r, output logic [4:0] d,
                        output logic wo);
    start_op(7'b0000001, f3, rd, a, b);
    l = 1;
    while (ready !== 1'b1 && l < 40) begin
      @(posedge clk);
      #1;
      l++;
    end
    r  = result;
    d  = dest;
    wo = wr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_wr", {31'b0, wr}, 32'd0);
    chk("rst_dest", {27'b0, dest}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // MUL 7 * -3, full latency, plus busy on the first CALC cycle
    start_op(7'b0000001, 3'd0, 5'd5, 32'd7, 32'hFFFFFFFD);
    chk("mul_busy", {31'b0, busy}, 32'd1);
    lat = 1;
    while (ready !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("mul_lat", lat, mul_lat(32'hFFFFFFFD));
    chk("mul_res", result, 32'hFFFFFFEB);
    chk("mul_dest", {27'b0, dest}, 32'd5);
    chk("mul_wr", {31'b0, wr}, 32'd1);
    chk("mul_busy_done", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk("mul_ready_after", {31'b0, ready}, 32'd0);
    chk("mul_wr_after", {31'b0, wr}, 32'd0);
    chk("mul_res_hold", result, 32'hFFFFFFEB);
    chk("mul_dest_hold", {27'b0, dest}, 32'd5);

    // MUL 7 * 3 (short multiplier)
    run_op(3'd0, 5'd6, 32'd7, 32'd3, lat, res, dst, w);
    chk("mul3_lat", lat, mul_lat(32'd3));
    chk("mul3_res", res, 32'd21);
    chk("mul3_dest", {27'b0, dst}, 32'd6);

    // High-half multiplies
    run_op(3'd3, 5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, dst, w);
    chk("mulhu_lat", lat, mul_lat(32'hFFFFFFFF));
    chk("mulhu_res", res, 32'hFFFFFFFE);
    run_op(3'd1, 5'd11, 32'h80000000, 32'd2, lat, res, dst, w);
    chk("mulh_lat", lat, mul_lat(32'd2));
    chk("mulh_res", res, 32'hFFFFFFFF);
    run_op(3'd2, 5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, dst, w);
    chk("mulhsu_lat", lat, mul_lat(32'hFFFFFFFF));
    chk("mulhsu_res", res, 32'hFFFFFFFF);

    // Divide / remainder, signed and unsigned
    run_op(3'd4, 5'd13, 32'hFFFFFFF9, 32'd2, lat, res, dst, w);
    chk("div_lat", lat, 33);
    chk("div_res", res, 32'hFFFFFFFD);
    run_op(3'd6, 5'd14, 32'hFFFFFFF9, 32'd2, lat, res, dst, w);
    chk("rem_res", res, 32'hFFFFFFFF);
    run_op(3'd5, 5'd15, 32'd100, 32'd7, lat, res, dst, w);
    chk("divu_lat", lat, 33);
    chk("divu_res", res, 32'd14);
    run_op(3'd7, 5'd16, 32'd100, 32'd7, lat, res, dst, w);
    chk("remu_res", res, 32'd2);
    chk("remu_dest", {27'b0, dst}, 32'd16);

    // Fast path: divide by zero and signed overflow
    run_op(3'd5, 5'd17, 32'd5, 32'd0, lat, res, dst, w);
    chk("divu0_lat", lat, 1);
    chk("divu0_res", res, 32'hFFFFFFFF);
    chk("divu0_dest", {27'b0, dst}, 32'd17);
    run_op(3'd7, 5'd18, 32'd5, 32'd0, lat, res, dst, w);
    chk("remu0_lat", lat, 1);
    chk("remu0_res", res, 32'd5);
    run_op(3'd4, 5'd19, 32'h80000000, 32'hFFFFFFFF, lat, res, dst, w);
    chk("divovf_lat", lat, 1);
    chk("divovf_res", res, 32'h80000000);
    run_op(3'd6, 5'd20, 32'h80000000, 32'hFFFFFFFF, lat, res, dst, w);
    chk("removf_lat", lat, 1);
    chk("removf_res", res, 32'd0);
    run_op(3'd6, 5'd21, 32'hFFFFFFFB, 32'd0, lat, res, dst, w);
    chk("rem0_lat", lat, 1);
    chk("rem0_res", res, 32'hFFFFFFFB);

    // MUL to x0: ready without register write
    run_op(3'd0, 5'd0, 32'd3, 32'd4, lat, res, dst, w);
    chk("mulx0_lat", lat, mul_lat(32'd4));
    chk("mulx0_res", res, 32'd12);
    chk("mulx0_wr", {31'b0, w}, 32'd0);
    chk("mulx0_dest", {27'b0, dst}, 32'd0);

    // ADD flagged invalid_inst is ignored
    start_op(7'b0000000, 3'd0, 5'd4, 32'd1, 32'd1);
    chk("add_busy", {31'b0, busy}, 32'd0);
    chk("add_ready", {31'b0, ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("add_idle", {30'b0, busy, ready}, 32'd0);

    // Valid M op with simultaneous flush is not accepted
    @(negedge clk);
    flush = 1'b1;
    start_op(7'b0000001, 3'd5, 5'd4, 32'd100, 32'd7);
    flush = 1'b0;
    chk("flushacc_busy", {31'b0, busy}, 32'd0);
    chk("flushacc_ready", {31'b0, ready}, 32'd0);

    // Flush in CALC cycle 10, then a back-to-back op
    start_op(7'b0000001, 3'd5, 5'd9, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("flush_busy_pre", {31'b0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_ready", {31'b0, ready}, 32'd0);
    chk("flush_res_hold", result, 32'd12);
    chk("flush_dest_hold", {27'b0, dest}, 32'd0);
    run_op(3'd5, 5'd9, 32'd100, 32'd7, lat, res, dst, w);
    chk("b2b_lat", lat, 33);
    chk("b2b_res", res, 32'd14);
    chk("b2b_dest", {27'b0, dst}, 32'd9);

    // Asynchronous reset in CALC cycle 5
    start_op(7'b0000001, 3'd3, 5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("rst5_busy_pre", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst5_busy", {31'b0, busy}, 32'd0);
    chk("rst5_ready", {31'b0, ready}, 32'd0);
    chk("rst5_wr", {31'b0, wr}, 32'd0);
    chk("rst5_dest", {27'b0, dest}, 32'd0);
    chk("rst5_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    chk("rst5_no_done", {30'b0, busy, ready}, 32'd0);

    // Recovery after reset
    run_op(3'd7, 5'd3, 32'd100, 32'd7, lat, res, dst, w);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_res", res, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
